// File: rtl/issue_buffer_pkg.sv
// Shared definitions for the issue-path slice: opcode constants and the
// helper that derives register-index width from the register count.
package issue_buffer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LD  = 3'd5,
    OP_ST  = 3'd6,
    OP_BR  = 3'd7
  } opcode_e;

  function automatic int reg_id_bits(input int num_reg);
    return (num_reg > 1) ? $clog2(num_reg) : 1;
  endfunction

endpackage

// File: rtl/issue_buffer_if.sv
// Issue-side and dispatch-side handshake bundle of an issue buffer.
// master = scoreboard/consumer side, slave = the buffer itself.
interface issue_buffer_if
  import issue_buffer_pkg::*;
#(
  parameter int INST_ID_BIT = 8,
  parameter int NUM_REG     = 8,
  parameter int IMM_BIT     = 4,
  parameter int REG_ID_BIT  = reg_id_bits(NUM_REG)
) ();

  logic                   in_vld;
  logic                   in_rdy;
  logic [INST_ID_BIT-1:0] in_id;
  logic [REG_ID_BIT-1:0]  in_dst_reg;
  logic [REG_ID_BIT-1:0]  in_src_reg0;
  logic [REG_ID_BIT-1:0]  in_src_reg1;
  logic [IMM_BIT-1:0]     in_imm;
  logic [NUM_REG-1:0]     ready_reg_mask;
  logic [NUM_REG-1:0]     pending_read;
  logic                   out_vld;
  logic                   out_rdy;
  logic [INST_ID_BIT-1:0] out_id;
  logic [REG_ID_BIT-1:0]  out_dst_reg;
  logic [REG_ID_BIT-1:0]  out_src_reg0;
  logic [REG_ID_BIT-1:0]  out_src_reg1;
  logic [IMM_BIT-1:0]     out_imm;
  logic                   empty;

  modport master (
    output in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1, in_imm,
           ready_reg_mask, out_rdy,
    input  in_rdy, pending_read, out_vld, out_id, out_dst_reg,
           out_src_reg0, out_src_reg1, out_imm, empty
  );

  modport slave (
    input  in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1, in_imm,
           ready_reg_mask, out_rdy,
    output in_rdy, pending_read, out_vld, out_id, out_dst_reg,
           out_src_reg0, out_src_reg1, out_imm, empty
  );

endinterface

// File: rtl/issue_buffer_decoder_onehot.sv
// Binary-to-one-hot decoder: out = 1 << in.
module decoder_onehot #(
  parameter int DATA_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]      in,
  output logic [(2**DATA_WIDTH)-1:0] out
);

  assign out = ((2**DATA_WIDTH))'(1) << in;

endmodule

// File: rtl/issue_buffer.sv
// Age-ordered issue buffer: slot 0 is oldest, pops compact younger slots down.
// Dispatches in FIFO order or oldest-ready-first depending on IN_ORDER.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int SIZE        = 4,
  parameter int INST_ID_BIT = 8,
  parameter int NUM_REG     = 8,
  parameter int IMM_BIT     = 4,
  parameter int IN_ORDER    = 0,
  parameter int REG_ID_BIT  = reg_id_bits(NUM_REG)
) (
  input logic           clk,
  input logic           rst_n,
  issue_buffer_if.slave bus
);

  localparam int SEL_BIT = $clog2(SIZE);
  localparam int CNT_BIT = $clog2(SIZE + 1);
  localparam int DEC_W   = 2**REG_ID_BIT;

  logic [SIZE-1:0]        r_vld;
  logic [INST_ID_BIT-1:0] r_id   [SIZE];
  logic [REG_ID_BIT-1:0]  r_dst  [SIZE];
  logic [REG_ID_BIT-1:0]  r_src0 [SIZE];
  logic [REG_ID_BIT-1:0]  r_src1 [SIZE];
  logic [IMM_BIT-1:0]     r_imm  [SIZE];

  logic [SIZE-1:0]        w_up_vld;
  logic [INST_ID_BIT-1:0] w_up_id   [SIZE];
  logic [REG_ID_BIT-1:0]  w_up_dst  [SIZE];
  logic [REG_ID_BIT-1:0]  w_up_src0 [SIZE];
  logic [REG_ID_BIT-1:0]  w_up_src1 [SIZE];
  logic [IMM_BIT-1:0]     w_up_imm  [SIZE];

  logic [DEC_W-1:0]       w_dec0 [SIZE];
  logic [DEC_W-1:0]       w_dec1 [SIZE];
  logic [SIZE-1:0]        w_src_rdy;

  logic                   w_found;
  logic [SEL_BIT-1:0]     w_sel;
  logic [CNT_BIT-1:0]     w_count;
  logic [CNT_BIT-1:0]     w_wr_idx;
  logic [NUM_REG-1:0]     w_pend;
  logic                   w_in_rdy;
  logic                   w_push;
  logic                   w_pop;

  for (genvar g = 0; g < SIZE; g++) begin : g_slot
    decoder_onehot #(.DATA_WIDTH(REG_ID_BIT)) u_dec0 (.in(r_src0[g]), .out(w_dec0[g]));
    decoder_onehot #(.DATA_WIDTH(REG_ID_BIT)) u_dec1 (.in(r_src1[g]), .out(w_dec1[g]));

    assign w_src_rdy[g] = (|(w_dec0[g][NUM_REG-1:0] & bus.ready_reg_mask)) &&
                          (|(w_dec1[g][NUM_REG-1:0] & bus.ready_reg_mask));

    // Each slot's view of its younger neighbour, used when compacting after a pop.
    if (g < SIZE - 1) begin : g_mid
      assign w_up_vld[g]  = r_vld[g+1];
      assign w_up_id[g]   = r_id[g+1];
      assign w_up_dst[g]  = r_dst[g+1];
      assign w_up_src0[g] = r_src0[g+1];
      assign w_up_src1[g] = r_src1[g+1];
      assign w_up_imm[g]  = r_imm[g+1];
    end else begin : g_top
      assign w_up_vld[g]  = 1'b0;
      assign w_up_id[g]   = r_id[g];
      assign w_up_dst[g]  = r_dst[g];
      assign w_up_src0[g] = r_src0[g];
      assign w_up_src1[g] = r_src1[g];
      assign w_up_imm[g]  = r_imm[g];
    end
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_count = '0;
    w_pend  = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (!w_found && r_vld[i] && ((IN_ORDER != 0) ? (i == 0) : w_src_rdy[i])) begin
        w_found = 1'b1;
        w_sel   = SEL_BIT'(i);
      end
      if (r_vld[i]) begin
        w_count = w_count + CNT_BIT'(1);
        w_pend  = w_pend | w_dec0[i][NUM_REG-1:0] | w_dec1[i][NUM_REG-1:0];
      end
    end
  end

  assign w_in_rdy = (w_count < CNT_BIT'(SIZE));
  assign w_push   = bus.in_vld && w_in_rdy;
  assign w_pop    = w_found && bus.out_rdy;
  assign w_wr_idx = w_count - CNT_BIT'(w_pop);

  // NOTE: state updates use non-blocking assignments so every slot sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (w_push && (CNT_BIT'(i) == w_wr_idx)) begin
          r_vld[i] <= 1'b1;
        end else if (w_pop && (SEL_BIT'(i) >= w_sel)) begin
          r_vld[i] <= w_up_vld[i];
        end
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (w_push && (CNT_BIT'(i) == w_wr_idx)) begin
        r_id[i]   <= bus.in_id;
        r_dst[i]  <= bus.in_dst_reg;
        r_src0[i] <= bus.in_src_reg0;
        r_src1[i] <= bus.in_src_reg1;
        r_imm[i]  <= bus.in_imm;
      end else if (w_pop && (SEL_BIT'(i) >= w_sel)) begin
        r_id[i]   <= w_up_id[i];
        r_dst[i]  <= w_up_dst[i];
        r_src0[i] <= w_up_src0[i];
        r_src1[i] <= w_up_src1[i];
        r_imm[i]  <= w_up_imm[i];
      end
    end
  end

  assign bus.in_rdy       = w_in_rdy;
  assign bus.empty        = (w_count == '0);
  assign bus.pending_read = w_pend;
  assign bus.out_vld      = w_found;
  assign bus.out_id       = r_id[w_sel];
  assign bus.out_dst_reg  = r_dst[w_sel];
  assign bus.out_src_reg0 = r_src0[w_sel];
  assign bus.out_src_reg1 = r_src1[w_sel];
  assign bus.out_imm      = r_imm[w_sel];

endmodule

// File: tb/tb_issue_buffer.sv
// Drives a FIFO-mode and a station-mode issue buffer with the same stimulus
// and checks both against a queue-based model every cycle.
module tb_issue_buffer;

  localparam int SIZE = 4;

  typedef struct packed {
    logic [7:0] id;
    logic [2:0] dst;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [3:0] imm;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic       t_vld;
  logic [7:0] t_id;
  logic [2:0] t_dst;
  logic [2:0] t_s0;
  logic [2:0] t_s1;
  logic [3:0] t_imm;
  logic [7:0] t_mask;
  logic       t_ordy;

  int n_cmp = 0;
  int n_err = 0;

  ent_t mq_f[$];
  ent_t mq_r[$];
  int   kf, kr;
  bit   pf, pr;

  issue_buffer_if bus_f ();
  issue_buffer_if bus_r ();

  assign bus_f.in_vld = t_vld;  assign bus_r.in_vld = t_vld;
  assign bus_f.in_id = t_id;    assign bus_r.in_id = t_id;
  assign bus_f.in_dst_reg = t_dst;  assign bus_r.in_dst_reg = t_dst;
  assign bus_f.in_src_reg0 = t_s0;  assign bus_r.in_src_reg0 = t_s0;
  assign bus_f.in_src_reg1 = t_s1;  assign bus_r.in_src_reg1 = t_s1;
  assign bus_f.in_imm = t_imm;  assign bus_r.in_imm = t_imm;
  assign bus_f.ready_reg_mask = t_mask;  assign bus_r.ready_reg_mask = t_mask;
  assign bus_f.out_rdy = t_ordy;  assign bus_r.out_rdy = t_ordy;

  issue_buffer #(.SIZE(SIZE), .IN_ORDER(1)) u_fifo (.clk(clk), .rst_n(rst_n), .bus(bus_f));
  issue_buffer #(.SIZE(SIZE), .IN_ORDER(0)) u_rs   (.clk(clk), .rst_n(rst_n), .bus(bus_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the entry that must be offered, or -1 when nothing may dispatch.
  function automatic int sel_idx(input ent_t q[$], input logic [7:0] mask, input bit in_order);
    for (int i = 0; i < q.size(); i++) begin
      if (in_order) return 0;
      if (mask[q[i].s0] && mask[q[i].s1]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pend(input ent_t q[$]);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < q.size(); i++) p = p | (8'(1) << q[i].s0) | (8'(1) << q[i].s1);
    return p;
  endfunction

  task automatic cmp_dut(input string tag, input ent_t q[$], input bit in_order,
                         input logic a_empty, input logic a_in_rdy, input logic a_out_vld,
                         input logic [7:0] a_pend, input ent_t a_out);
    int k;
    k = sel_idx(q, t_mask, in_order);
    check({tag, ".empty"}, 32'(a_empty), 32'(q.size() == 0));
    check({tag, ".in_rdy"}, 32'(a_in_rdy), 32'(q.size() < SIZE));
    check({tag, ".out_vld"}, 32'(a_out_vld), 32'(k >= 0));
    check({tag, ".pending_read"}, 32'(a_pend), 32'(pend(q)));
    if (k >= 0) check({tag, ".out_entry"}, 32'(a_out), 32'(q[k]));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_f.delete();
      mq_r.delete();
    end else begin
      kf = sel_idx(mq_f, t_mask, 1'b1);
      kr = sel_idx(mq_r, t_mask, 1'b0);
      pf = t_vld && (mq_f.size() < SIZE);
      pr = t_vld && (mq_r.size() < SIZE);
      if (kf >= 0 && t_ordy) mq_f.delete(kf);
      if (kr >= 0 && t_ordy) mq_r.delete(kr);
      if (pf) mq_f.push_back({t_id, t_dst, t_s0, t_s1, t_imm});
      if (pr) mq_r.push_back({t_id, t_dst, t_s0, t_s1, t_imm});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_dut("fifo", mq_f, 1'b1, bus_f.empty, bus_f.in_rdy, bus_f.out_vld, bus_f.pending_read,
              {bus_f.out_id, bus_f.out_dst_reg, bus_f.out_src_reg0, bus_f.out_src_reg1, bus_f.out_imm});
      cmp_dut("rs", mq_r, 1'b0, bus_r.empty, bus_r.in_rdy, bus_r.out_vld, bus_r.pending_read,
              {bus_r.out_id, bus_r.out_dst_reg, bus_r.out_src_reg0, bus_r.out_src_reg1, bus_r.out_imm});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] id, input logic [2:0] dst, input logic [2:0] s0,
                      input logic [2:0] s1, input logic [3:0] imm);
    t_vld = 1'b1; t_id = id; t_dst = dst; t_s0 = s0; t_s1 = s1; t_imm = imm;
    step();
    t_vld = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    t_vld = 1'b0; t_id = '0; t_dst = '0; t_s0 = '0; t_s1 = '0; t_imm = '0;
    t_mask = 8'hFF; t_ordy = 1'b0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    step();

    // Idle after reset
    check("idle.empty", 32'(bus_f.empty), 32'd1);
    check("idle.in_rdy", 32'(bus_f.in_rdy), 32'd1);
    check("idle.out_vld", 32'(bus_r.out_vld), 32'd0);
    check("idle.pending", 32'(bus_r.pending_read), 32'h00);

    // FIFO order and pending-read mask
    push(8'd1, 3'd1, 3'd2, 3'd3, 4'd1);
    push(8'd2, 3'd2, 3'd4, 3'd5, 4'd2);
    push(8'd3, 3'd3, 3'd6, 3'd7, 4'd3);
    check("fifo3.pending", 32'(bus_f.pending_read), 32'hFC);
    t_ordy = 1'b1;
    check("pop1.id", 32'(bus_f.out_id), 32'd1);
    step();
    check("pop2.id", 32'(bus_f.out_id), 32'd2);
    step();
    check("pop3.id", 32'(bus_f.out_id), 32'd3);
    step();
    t_ordy = 1'b0;
    check("drained.empty", 32'(bus_f.empty), 32'd1);
    check("drained.pending", 32'(bus_f.pending_read), 32'h00);

    // Full behaviour: refused push, and push+pop at full only pops
    for (int i = 0; i < SIZE; i++) push(8'(10 + i), 3'd0, 3'd0, 3'd1, 4'(i));
    check("full.in_rdy", 32'(bus_f.in_rdy), 32'd0);
    t_vld = 1'b1; t_id = 8'd9;
    step();
    check("full_rej.head", 32'(bus_f.out_id), 32'd10);
    t_ordy = 1'b1;
    step();
    t_vld = 1'b0;
    t_ordy = 1'b0;
    check("full_pp.in_rdy", 32'(bus_f.in_rdy), 32'd1);
    check("full_pp.head", 32'(bus_f.out_id), 32'd11);
    t_ordy = 1'b1;
    step(); step(); step();
    t_ordy = 1'b0;
    check("full_drain.empty", 32'(bus_f.empty), 32'd1);

    // Station: younger ready entry bypasses older blocked one
    reset_pulse();
    t_mask = 8'h08;
    push(8'd5, 3'd0, 3'd1, 3'd2, 4'd0);
    push(8'd6, 3'd4, 3'd3, 3'd3, 4'd0);
    check("rs_b.vld", 32'(bus_r.out_vld), 32'd1);
    check("rs_b.id", 32'(bus_r.out_id), 32'd6);
    check("fifo_a.id", 32'(bus_f.out_id), 32'd5);
    t_ordy = 1'b1;
    step();
    t_ordy = 1'b0;
    t_mask = 8'hFF;
    #1;
    check("rs_a.id", 32'(bus_r.out_id), 32'd5);
    t_ordy = 1'b1;
    step();
    t_ordy = 1'b0;
    check("rs_ab.empty", 32'(bus_r.empty), 32'd1);

    // Station: nothing ready, out_rdy has no effect
    reset_pulse();
    t_mask = 8'h00;
    push(8'd20, 3'd0, 3'd1, 3'd2, 4'd0);
    push(8'd21, 3'd0, 3'd3, 3'd4, 4'd0);
    check("rs_blk.vld", 32'(bus_r.out_vld), 32'd0);
    check("rs_blk.empty", 32'(bus_r.empty), 32'd0);
    t_ordy = 1'b1;
    step();
    t_ordy = 1'b0;
    check("rs_blk2.vld", 32'(bus_r.out_vld), 32'd0);
    t_mask = 8'hFF;
    #1;
    check("rs_rel.vld", 32'(bus_r.out_vld), 32'd1);
    check("rs_rel.id", 32'(bus_r.out_id), 32'd20);
    t_ordy = 1'b1;
    step(); step();
    t_ordy = 1'b0;

    // Asynchronous reset mid-stream
    push(8'd30, 3'd0, 3'd5, 3'd6, 4'd0);
    push(8'd31, 3'd0, 3'd5, 3'd6, 4'd0);
    push(8'd32, 3'd0, 3'd5, 3'd6, 4'd0);
    check("pre_rst.pending", 32'(bus_f.pending_read), 32'h60);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.fifo.empty", 32'(bus_f.empty), 32'd1);
    check("async.fifo.pending", 32'(bus_f.pending_read), 32'h00);
    check("async.rs.empty", 32'(bus_r.empty), 32'd1);
    check("async.rs.pending", 32'(bus_r.pending_read), 32'h00);
    #2;
    rst_n = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
- Per-functional-unit issue buffer between the scoreboard/dispatch and the unit's register-read stage.
- Holds up to SIZE issued instructions.
- Dispatches them either strictly in issue order (IN_ORDER=1, FIFO) or oldest-ready-first (IN_ORDER=0, reservation station gated by ready_reg_mask).
- Exports a mask of source registers still awaiting read, for WAR protection.

Parameters:
- SIZE, 4, number of entries (>=2).
- INST_ID_BIT, 8, instruction-id width.
- NUM_REG, 8, architectural register count.
- IMM_BIT, 4, immediate width.
- IN_ORDER, 0, 1 = FIFO dispatch; 0 = out-of-order station.
- REG_ID_BIT, $clog2(NUM_REG), register-index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_vld  in  1  issue request.
- in_rdy  out  1  buffer can accept.
- in_id  in  INST_ID_BIT  instruction id.
- in_dst_reg  in  REG_ID_BIT  destination register.
- in_src_reg0  in  REG_ID_BIT  source register 0.
- in_src_reg1  in  REG_ID_BIT  source register 1.
- in_imm  in  IMM_BIT  immediate.
- ready_reg_mask  in  NUM_REG  bit r=1 means register r has no pending write (unused when IN_ORDER=1).
- pending_read  out  NUM_REG  OR of source registers of all valid entries.
- out_vld  out  1  selected entry available.
- out_rdy  in  1  consumer takes selected entry.
- out_id  out  INST_ID_BIT  selected entry id.
- out_dst_reg  out  REG_ID_BIT  selected entry destination.
- out_src_reg0  out  REG_ID_BIT  selected entry source 0.
- out_src_reg1  out  REG_ID_BIT  selected entry source 1.
- out_imm  out  IMM_BIT  selected entry immediate.
- empty  out  1  no valid entries.

Behaviour:
- Storage: SIZE entries kept age-ordered; slot 0 is oldest; per-slot valid bit; count = number of valid slots.
- Reset: all valid bits 0, so empty=1, in_rdy=1, out_vld=0, pending_read=0. Payload registers are not reset.
- in_rdy = (count < SIZE), combinational. It does not depend on a same-cycle pop, so a full buffer refuses input even while popping.
- Push on in_vld && in_rdy: entry written to slot count (after any compaction from a same-cycle pop). Visible at outputs the next cycle; zero-latency bypass not allowed.
- Selection, IN_ORDER=1: candidate is slot 0; out_vld = valid[0]; ready_reg_mask ignored.
- Selection, IN_ORDER=0: candidate is the lowest-index valid slot with ready_reg_mask[src0] && ready_reg_mask[src1]. out_vld=1 if any such slot exists.
- out_* are combinational from the candidate slot. With no candidate they show slot 0 contents (don't care). In station mode the candidate may change between cycles while out_rdy=0.
- Pop on out_vld && out_rdy: candidate removed; all younger slots shift down by one at the clock edge, preserving age order.
- Simultaneous push and pop: both performed; count unchanged; new entry lands at slot count-1.
- out_rdy while out_vld=0: no effect.
- pending_read = OR over valid slots of decode(src_reg0) | decode(src_reg1), truncated to NUM_REG bits. Combinational from current state.
- empty = (count == 0).
- Reset asserted mid-operation clears all entries immediately (asynchronous).

Decomposition:
- Shared package: OP_* opcode constants plus REG_ID_BIT derivation helper. This block uses none of the opcodes.
- One sub-module: decoder_onehot, parameter DATA_WIDTH, in[DATA_WIDTH], out[2**DATA_WIDTH]; out = 1 << in. Instantiated twice per slot.

Test Plan:
- Reset, then idle: empty=1, in_rdy=1, out_vld=0, pending_read=8'h00.
- IN_ORDER=1: push ids 1,2,3 (srcs 2/3, 4/5, 6/7) with out_rdy=0 → pending_read=8'hFC. Pop thrice → ids 1,2,3 in order; pending_read reaches 0; empty=1.
- Fill 4 entries → in_rdy=0. Push attempt with id 9 is ignored. A same-cycle push+pop at full pops one and rejects the push; count becomes 3.
- IN_ORDER=0: entries A(id 5, srcs r1,r2) and B(id 6, srcs r3,r3); ready_reg_mask=8'b0000_1000 → out_id=6. Pop B; set mask 8'hFF → out_id=5.
- IN_ORDER=0 with mask 8'h00 and 2 entries: out_vld=0, empty=0. Mask going to 8'hFF → out_vld=1 with the oldest id.
- Async reset asserted with 3 entries mid-stream → empty=1 and pending_read=0 before the next clk edge.
